// File: rtl/updown_counter.sv
// updown_counter: up/down counter over 0..MAX with wrap or saturate at the ends.
// Ports: clk, n_rst (async, active-low), clear/load/load_val/en/up controls;
//        count (registered), at_max/at_zero (combinational from count),
//        wrap (registered one-cycle range-end pulse), ovf (sticky range-end flag).
// Optional feature: define UPDOWN_COUNTER_OVF_STICKY_EN to register ovf;
//        otherwise ovf is tied to 0 and no flop is built.
module updown_counter #(
    parameter int WIDTH    = 8,
    parameter int MAX      = 255,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_zero,
    output logic             wrap,
    output logic             ovf
);

    // One extra bit so MAX = 2^WIDTH-1 compares and steps without carry loss.
    localparam logic [WIDTH:0] MAX_X = (WIDTH+1)'(MAX);
    localparam logic [WIDTH:0] ONE_X = (WIDTH+1)'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH:0]   cnt_x, ld_x, nxt_x;
    logic             unused_msb;

    always_comb begin
        cnt_x  = {1'b0, count_q};
        ld_x   = {1'b0, load_val};
        nxt_x  = cnt_x;
        wrap_d = 1'b0;
        if (clear) begin
            nxt_x = '0;
        end else if (load) begin
            nxt_x = (ld_x > MAX_X) ? MAX_X : ld_x;
        end else if (en) begin
            if (up) begin
                if (cnt_x >= MAX_X) begin
                    wrap_d = 1'b1;
                    nxt_x  = SATURATE ? MAX_X : '0;
                end else begin
                    nxt_x = cnt_x + ONE_X;
                end
            end else begin
                if (cnt_x == '0) begin
                    wrap_d = 1'b1;
                    nxt_x  = SATURATE ? '0 : MAX_X;
                end else begin
                    nxt_x = cnt_x - ONE_X;
                end
            end
        end
        count_d = nxt_x[WIDTH-1:0];
    end

    // The top bit never reaches a flop: the result is always within 0..MAX.
    assign unused_msb = nxt_x[WIDTH];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

`ifdef UPDOWN_COUNTER_OVF_STICKY_EN
    logic ovf_q, ovf_d;

    // Load leaves the flag alone; only clear or reset drops it.
    always_comb begin
        ovf_d = clear ? 1'b0 : (ovf_q | wrap_d);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign count   = count_q;
    assign wrap    = wrap_q;
    assign at_max  = ({1'b0, count_q} == MAX_X);
    assign at_zero = (count_q == '0);

endmodule

// File: doc/updown_counter.md
UPDOWN_COUNTER -- requirements
Module: updown_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning count register width in bits (WIDTH >= 1).
REQ-002 SHALL have parameter MAX, default 255, meaning terminal count; legal range 0..MAX is the count range (MAX <= 2^WIDTH-1).
REQ-003 SHALL have parameter SATURATE, default 0, meaning 0 = wrap at range ends, 1 = hold at range ends.
REQ-004 SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port n_rst, input, 1 bit, meaning asynchronous active-low reset.
REQ-006 SHALL have port clear, input, 1 bit, meaning synchronous clear to 0.
REQ-007 SHALL have port load, input, 1 bit, meaning synchronous parallel load of load_val.
REQ-008 SHALL have port load_val, input, WIDTH bits, meaning value to load.
REQ-009 SHALL have port en, input, 1 bit, meaning count enable.
REQ-010 SHALL have port up, input, 1 bit, meaning direction: 1 = increment, 0 = decrement.
REQ-011 SHALL have port count, output, WIDTH bits, meaning current registered count.
REQ-012 SHALL have port at_max, output, 1 bit, meaning count == MAX (combinational from count).
REQ-013 SHALL have port at_zero, output, 1 bit, meaning count == 0 (combinational from count).
REQ-014 SHALL have port wrap, output, 1 bit, meaning registered one-cycle pulse marking a range-end event.
REQ-015 SHALL have port ovf, output, 1 bit, meaning sticky range-end flag (see Configuration).

Function
REQ-016 SHALL apply per-edge priority: clear > load > en; with none asserted, count holds.
REQ-017 SHALL, on clear, set count to 0 and drive wrap to 0 on the next cycle.
REQ-018 SHALL, on load, set count to load_val, or to MAX if load_val > MAX; wrap is 0 on the next cycle.
REQ-019 SHALL, on en with up=1 and count < MAX, set count to count+1; with up=0 and count > 0, set count to count-1.
REQ-020 SHALL, with SATURATE=0, en, up=1 and count == MAX, set count to 0 and pulse wrap high for exactly one cycle.
REQ-021 SHALL, with SATURATE=0, en, up=0 and count == 0, set count to MAX and pulse wrap high for exactly one cycle.
REQ-022 SHALL, with SATURATE=1, hold count at a range end when en pushes past it, and pulse wrap for one cycle (event = blocked step).
REQ-023 SHALL, with MAX == 0, hold count at 0 under en, with wrap pulsing on every enabled cycle.
REQ-024 SHALL compute next count at WIDTH+1 bits internally, so MAX = 2^WIDTH-1 produces no carry loss or spurious compare.
REQ-025 SHALL assert wrap on consecutive cycles when range-end events occur on consecutive enabled cycles (e.g. MAX=0).
REQ-026 SHALL produce count and wrap from flops only; at_max and at_zero are the only combinational outputs.

Reset
REQ-027 SHALL, while n_rst is low, asynchronously force count=0, wrap=0, ovf=0, independent of clk.
REQ-028 SHALL, on n_rst deassertion, resume operation at the first rising clk edge with count=0; a reset mid-count discards the count.
REQ-029 SHALL drive at_zero=1, and at_max=1 only when MAX == 0, during and immediately after reset.

Configuration
REQ-030 SHALL, when macro UPDOWN_COUNTER_OVF_STICKY_EN is defined, register ovf: set on any cycle where wrap is being set, cleared only by clear or reset; load does not clear ovf.
REQ-031 SHALL, when UPDOWN_COUNTER_OVF_STICKY_EN is undefined, tie ovf to constant 0, instantiate no ovf flop, and leave the port list unchanged.

Verification
REQ-032 SHALL cover wrap up: WIDTH=4, MAX=9, SATURATE=0, load 9, en=1, up=1 -> count 0 next cycle, wrap=1 for one cycle, then count 1 with wrap=0.
REQ-033 SHALL cover wrap down: MAX=9, count 0, en=1, up=0 -> count 9, wrap pulse, at_max=1.
REQ-034 SHALL cover saturate: SATURATE=1, MAX=9, count 9, en=1, up=1 for 3 cycles -> count stays 9, wrap high all 3 cycles.
REQ-035 SHALL cover priority and clamp: clear=1, load=1, load_val=5, en=1 -> count 0; then load=1, load_val=15, MAX=9 -> count 9.
REQ-036 SHALL cover async reset: count 7, n_rst low mid-cycle -> count 0, wrap 0, ovf 0 before the next clk edge.
REQ-037 SHALL cover the macro: with UPDOWN_COUNTER_OVF_STICKY_EN, one wrap -> ovf=1 held through a load of 3 until clear; without the macro, the same stimulus -> ovf=0 throughout.
